// File: rtl/ex_mem_pipeline_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ex_mem_pipeline_ctrl                                     |
// | Description : Pipeline stall/flush controller. Arbitrates memory wait  |
// |               stalls, branch flushes, load-use bubbles and external    |
// |               halt, and drives per-stage enables and bubble clears.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ex_mem_pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use_hazard,
  input  logic        branch_taken_ex,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        id_ex_enable,
  output logic        ex_mem_enable,
  output logic        mem_wb_enable,
  output logic        if_id_clear,
  output logic        id_ex_clear,
  output logic        ex_mem_clear,
  output logic        mem_wb_clear,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count,
  output logic        mem_timeout
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [7:0] r_wait_cnt;
  logic       w_mem_stall;
  logic       w_flush;

  // Memory stall: a fresh miss in RUN, or a still-outstanding access in MEM_WAIT
  always_comb begin
    w_mem_stall = 1'b0;
    if (r_state == ST_RUN)
      w_mem_stall = mem_req & ~mem_ready;
    else if (r_state == ST_MEM_WAIT)
      w_mem_stall = ~mem_ready;
  end

  // A branch flush only takes effect in an active state with no memory stall
  always_comb begin
    w_flush = rst_n & branch_taken_ex & ~w_mem_stall &
              ((r_state == ST_RUN) | (r_state == ST_MEM_WAIT));
  end

  // Stage enables and bubble clears, prioritised memory > branch > load-use
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_clear   = 1'b0;
    id_ex_clear   = 1'b0;
    ex_mem_clear  = 1'b0;
    mem_wb_clear  = 1'b0;
    if (!rst_n) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      if_id_clear   = 1'b1;
      id_ex_clear   = 1'b1;
      ex_mem_clear  = 1'b1;
      mem_wb_clear  = 1'b1;
    end else if ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) begin
      if (w_mem_stall) begin
        // Freeze everything upstream of MEM; retire a bubble into WB
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_clear  = 1'b1;
      end else if (branch_taken_ex) begin
        // Kill the two wrong-path instructions behind the branch
        if_id_clear = 1'b1;
        id_ex_clear = 1'b1;
      end else if (load_use_hazard) begin
        // Hold fetch/decode one cycle and inject a bubble into EX
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_clear  = 1'b1;
      end
    end else begin
      // HALTED (or unreachable encoding): whole pipeline frozen
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
    end
  end

  // Next-state selection; halt is only honoured from RUN
  always_comb begin
    w_state_next = ST_RUN;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall)   w_state_next = ST_MEM_WAIT;
        else if (halt_req) w_state_next = ST_HALTED;
        else               w_state_next = ST_RUN;
      end
      ST_MEM_WAIT: w_state_next = mem_ready ? ST_RUN : ST_MEM_WAIT;
      ST_HALTED:   w_state_next = halt_req ? ST_HALTED : ST_RUN;
      default:     w_state_next = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // Memory wait counter and sticky timeout flag; counter parks at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= 8'd0;
      mem_timeout <= 1'b0;
    end else if ((r_state == ST_MEM_WAIT) && !mem_ready) begin
      if (r_wait_cnt != TIMEOUT_LIMIT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
        if (r_wait_cnt == TIMEOUT_LIMIT - 8'd1)
          mem_timeout <= 1'b1;
      end
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  // Saturating performance counters for frozen-PC cycles and branch flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
      flush_count  <= 8'd0;
    end else begin
      if (!pc_enable && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (w_flush && (flush_count != 8'hFF))
        flush_count <= flush_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipeline_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ex_mem_pipeline_ctrl                                  |
// | Description : Directed self-checking bench for ex_mem_pipeline_ctrl.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_ex_mem_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_use_hazard, branch_taken_ex, mem_req, mem_ready, halt_req;
  logic        pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic        if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;

  // Packed views: en = {pc, if_id, id_ex, ex_mem, mem_wb}, clr = {if_id, id_ex, ex_mem, mem_wb}
  logic [4:0] en;
  logic [3:0] clr;
  assign en  = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable};
  assign clr = {if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear};

  ex_mem_pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_use_hazard (load_use_hazard),
    .branch_taken_ex (branch_taken_ex),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .pc_enable       (pc_enable),
    .if_id_enable    (if_id_enable),
    .id_ex_enable    (id_ex_enable),
    .ex_mem_enable   (ex_mem_enable),
    .mem_wb_enable   (mem_wb_enable),
    .if_id_clear     (if_id_clear),
    .id_ex_clear     (id_ex_clear),
    .ex_mem_clear    (ex_mem_clear),
    .mem_wb_clear    (mem_wb_clear),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational outputs settle, then compare enables and clears
  task automatic check_out(input string tag, input logic [4:0] exp_en, input logic [3:0] exp_clr);
    #1;
    check({tag, ".en"}, int'(en), int'(exp_en));
    check({tag, ".clr"}, int'(clr), int'(exp_clr));
  endtask

  task automatic idle_inputs();
    load_use_hazard = 1'b0;
    branch_taken_ex = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    halt_req        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset state, before any clock edge
    check_out("reset", 5'b00000, 4'b1111);
    check("reset.stall", int'(stall_cycles), 0);
    check("reset.flush", int'(flush_count), 0);
    check("reset.tmo", int'(mem_timeout), 0);
    tick(); tick();
    rst_n = 1'b1;

    // Idle after reset
    check_out("idle", 5'b11111, 4'b0000);
    tick();
    check("idle.stall", int'(stall_cycles), 0);

    // Memory stall: 3 cycles miss, then ready
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_out("memstall", 5'b00001, 4'b0001);
      tick();
    end
    mem_ready = 1'b1;
    check_out("memdone", 5'b11111, 4'b0000);
    tick();
    check("memdone.stall", int'(stall_cycles), 3);
    check("memdone.tmo", int'(mem_timeout), 0);
    idle_inputs();

    // Load-use bubble, then normal
    load_use_hazard = 1'b1;
    check_out("loaduse", 5'b00111, 4'b0100);
    tick();
    check("loaduse.stall", int'(stall_cycles), 4);
    load_use_hazard = 1'b0;
    check_out("after_lu", 5'b11111, 4'b0000);
    tick();

    // Branch wins over load-use
    branch_taken_ex = 1'b1;
    load_use_hazard = 1'b1;
    check_out("br_lu", 5'b11111, 4'b1100);
    tick();
    check("br_lu.flush", int'(flush_count), 1);
    check("br_lu.stall", int'(stall_cycles), 4);
    idle_inputs();

    // Memory stall masks branch; branch honoured on MEM_WAIT exit
    mem_req = 1'b1;
    branch_taken_ex = 1'b1;
    check_out("mem_br", 5'b00001, 4'b0001);
    tick();
    check("mem_br.flush", int'(flush_count), 1);
    mem_ready = 1'b1;
    check_out("memexit_br", 5'b11111, 4'b1100);
    tick();
    check("memexit_br.flush", int'(flush_count), 2);
    check("memexit_br.stall", int'(stall_cycles), 5);
    idle_inputs();

    // Halt during MEM_WAIT deferred until RUN
    mem_req = 1'b1;
    tick();                               // RUN -> MEM_WAIT, stall 6
    halt_req = 1'b1;
    check_out("wait_halt", 5'b00001, 4'b0001);
    tick();                               // stall 7
    mem_ready = 1'b1;
    check_out("wait_exit", 5'b11111, 4'b0000);
    tick();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    check_out("run_halt", 5'b11111, 4'b0000);
    tick();                               // -> HALTED
    check("run_halt.stall", int'(stall_cycles), 7);
    check_out("halted", 5'b00000, 4'b0000);
    tick();
    check("halted.stall", int'(stall_cycles), 8);
    halt_req = 1'b0;
    check_out("halt_exit", 5'b00000, 4'b0000);
    tick();
    check("halt_exit.stall", int'(stall_cycles), 9);
    check_out("post_halt", 5'b11111, 4'b0000);
    halt_req = 1'b1;
    tick();                               // -> HALTED again
    check_out("halted2", 5'b00000, 4'b0000);

    // Asynchronous reset in HALTED
    rst_n = 1'b0;
    check_out("rst_halted", 5'b00000, 4'b1111);
    check("rst_halted.stall", int'(stall_cycles), 0);
    halt_req = 1'b0;
    tick();
    rst_n = 1'b1;
    check_out("rst_release", 5'b11111, 4'b0000);
    tick();
    check("rst_release.stall", int'(stall_cycles), 0);

    // Timeout with MEM_TIMEOUT=4, ready held low 6 cycles
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("tmo.early", int'(mem_timeout), 0);
    for (int i = 0; i < 3; i++) tick();
    check("tmo.set", int'(mem_timeout), 1);
    check("tmo.stall", int'(stall_cycles), 6);
    check_out("tmo.still_wait", 5'b00001, 4'b0001);
    mem_ready = 1'b1;
    check_out("tmo.exit", 5'b11111, 4'b0000);
    tick();
    idle_inputs();
    tick();
    check("tmo.sticky", int'(mem_timeout), 1);

    // flush_count saturation
    branch_taken_ex = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    check("flush.sat", int'(flush_count), 255);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipeline_ctrl.md
EX_MEM_PIPELINE_CTRL -- requirements
Module: ex_mem_pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255; maximum MEM_WAIT cycles before timeout flag (1..255).
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 load_use_hazard  input  1  ID-stage instruction needs the load result currently in EX.
REQ-005 branch_taken_ex  input  1  EX-stage branch/jump resolved taken; redirect in progress.
REQ-006 mem_req  input  1  MEM-stage instruction is a load or store.
REQ-007 mem_ready  input  1  data memory has completed the MEM-stage access this cycle.
REQ-008 halt_req  input  1  external request to freeze the whole pipeline.
REQ-009 pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  output  1 each  per-stage register enable.
REQ-010 if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear  output  1 each  per-stage synchronous bubble insert.
REQ-011 stall_cycles  output  16  saturating count of cycles with pc_enable=0.
REQ-012 flush_count  output  8  saturating count of branch flushes.
REQ-013 mem_timeout  output  1  sticky; set when a memory wait exceeds MEM_TIMEOUT cycles.

Function
REQ-014 States: RUN, MEM_WAIT, HALTED; all outputs except counters/flag are combinational from state and inputs (zero latency).
REQ-015 RUN, no events: all enables 1, all clears 0.
REQ-016 RUN, mem_req=1 and mem_ready=0: pc/if_id/id_ex/ex_mem enables 0, mem_wb_enable 1, mem_wb_clear 1; next state MEM_WAIT.
REQ-017 RUN, mem_req=1 and mem_ready=1 same cycle: no stall; evaluate other events normally.
REQ-018 MEM_WAIT, mem_ready=0: same outputs as REQ-016; stay MEM_WAIT; wait counter increments.
REQ-019 MEM_WAIT, mem_ready=1: outputs per RUN rules (REQ-015, REQ-020..022) this cycle; next state RUN; wait counter cleared.
REQ-020 Branch flush (RUN or MEM_WAIT exit, no memory stall): if_id_clear 1, id_ex_clear 1, all enables 1; flush_count +1.
REQ-021 Load-use (no branch, no memory stall): pc_enable 0, if_id_enable 0, id_ex_clear 1, ex_mem/mem_wb enables 1.
REQ-022 Priority: memory stall > branch flush > load-use; branch and load-use together -> flush only.
REQ-023 halt_req=1 in RUN with no memory stall: next state HALTED; that cycle outputs per RUN rules.
REQ-024 HALTED: all enables 0, all clears 0; exit to RUN when halt_req=0 (exit cycle outputs still frozen).
REQ-025 halt_req during MEM_WAIT ignored until return to RUN; it is then honoured if still asserted.
REQ-026 Wait counter 8-bit; when it reaches MEM_TIMEOUT, set mem_timeout; state remains MEM_WAIT.
REQ-027 stall_cycles +1 every cycle pc_enable=0 (including HALTED); saturates at 0xFFFF; flush_count saturates at 0xFF.
REQ-028 ex_mem_clear asserted only during reset (no EX-stage bubble source in this controller).

Reset
REQ-029 rst_n=0: state RUN, counters 0, mem_timeout 0, wait counter 0, immediately regardless of clk.
REQ-030 While rst_n=0: all enables 0, all clears 1; mid-MEM_WAIT or HALTED reset aborts to RUN.
REQ-031 First cycle after rst_n rises: RUN outputs per REQ-015..REQ-023.

Verification
REQ-032 Reset, then idle inputs -> all enables 1, clears 0, stall_cycles 0.
REQ-033 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles upstream frozen + mem_wb_clear, 4th cycle all enables 1; stall_cycles=3.
REQ-034 branch_taken_ex=1 with load_use_hazard=1 one cycle -> if_id_clear=id_ex_clear=1, pc_enable=1, flush_count=1.
REQ-035 load_use_hazard=1 one cycle -> pc_enable=0, if_id_enable=0, id_ex_clear=1; next cycle normal.
REQ-036 MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles -> mem_timeout=1 after wait counter reaches 4, stays 1 after mem_ready.
REQ-037 halt_req=1 during MEM_WAIT, mem_ready after 2 cycles -> RUN one cycle, then HALTED with all enables 0; rst_n pulse low mid-HALTED -> clears 1, then RUN.
